instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//  Initiator side of the 4-bit accumulator datapath control interface (ALU + accumulator + bus drivers).
//  Fetches 8-bit instructions from an external combinational program ROM, decodes them, and drives the
//  datapath controls: accumulator enable, bus-in driver, bus-out driver, ALU select and 4-bit operand.
//  Latches the datapath carry/zero flags for conditional jumps. Sits between program ROM and datapath.
// PARAMETERS
//  PC_W      8      program counter / ROM address width (jump target byte is PC_W bits, PC_W<=8)
//  RESET_PC  0      PC value loaded on reset
// PORTS
//  clk          in   1     system clock, all state updates on rising edge
//  reset        in   1     asynchronous, active-high; forces reset state immediately
//  run          in   1     1 = free-run; 0 = hold in FETCH (single-step by pulsing for one cycle)
//  prog_addr    out  PC_W  ROM address (= pc)
//  prog_data    in   8     ROM data for prog_addr, valid same cycle; [7:4] opcode, [3:0] operand
//  c_z          in   2     datapath flags: c_z[0] carry, c_z[1] zero
//  en_accu      out  1     accumulator load enable (datapath enable1)
//  en_bus_in    out  1     operand bus driver enable (datapath enable2)
//  en_bus_out   out  1     result output driver enable (datapath enable3)
//  alu_sel      out  3     ALU select: 0 ST, 1 COMPI, 2 LIT, 3 ADDI, 4 NANDI
//  operand      out  4     operand presented on datapath bus (ir[3:0])
//  flags        out  2     latched {zero, carry}; same bit order as c_z
//  halted       out  1     1 while in HALT state
// BEHAVIOUR
//  Reset: pc=RESET_PC, ir=0, flags=0, state=FETCH; all enables 0, alu_sel=0, operand=0, halted=0.
//  States: FETCH, EXEC, HALT (one-hot or binary, encoding from package).
//  FETCH: if run=1: ir<=prog_data, pc<=pc+1, ->EXEC. If run=0: hold, no pc change. Enables all 0.
//  EXEC: exactly one cycle; datapath controls decoded combinationally from ir (ir stable, glitch-free).
//   0x0 NOP  : no enables; ->FETCH
//   0x1 LIT  : alu_sel=2, en_bus_in=1, en_accu=1; flags<=c_z; ->FETCH
//   0x2 ADDI : alu_sel=3, en_bus_in=1, en_accu=1; flags<=c_z; ->FETCH
//   0x3 CMPI : alu_sel=1, en_bus_in=1, en_accu=0; flags<=c_z; ->FETCH
//   0x4 NANDI: alu_sel=4, en_bus_in=1, en_accu=1; flags<=c_z; ->FETCH
//   0x5 OUT  : alu_sel=0, en_bus_out=1, en_accu=0; flags unchanged; ->FETCH
//   0x6 JMP, 0x7 JC, 0x8 JNC, 0x9 JZ, 0xA JNZ: two-byte; in EXEC prog_addr=pc points at target byte.
//     condition on latched flags (JC carry=1, JNC carry=0, JZ zero=1, JNZ zero=0; JMP always).
//     taken: pc<=prog_data[PC_W-1:0]; not taken: pc<=pc+1 (skip target). No enables. ->FETCH
//   0xB-0xE: NOP. 0xF HALT: ->HALT, pc unchanged.
//  HALT: all enables 0, halted=1; leaves only on reset (run ignored).
//  Flags sampled at the rising edge ending EXEC, i.e. same edge the accumulator loads R.
//  Latency: 2 cycles per instruction (FETCH+EXEC) with run=1; jumps also 2 cycles.
//  pc arithmetic modulo 2^PC_W: 0xFF+1 -> 0x00; jump opcode at 0xFF reads target from 0x00.
//  run deasserted during EXEC: EXEC still completes; hold takes effect in next FETCH.
//  Reset mid-EXEC: enables drop asynchronously (state leaves EXEC), no flag update at that edge.
//  Outputs en_*, alu_sel, operand are 0 outside EXEC; operand=ir[3:0] only in EXEC.
// STRUCTURE
//  Shared package: opcode constants (OP_NOP..OP_HALT), ALU select codes (ALU_ST..ALU_NANDI),
//   state encoding, flag bit indices (FLAG_C=0, FLAG_Z=1).
//  One sub-module: seq_decode (combinational: opcode+state+flags -> enables, alu_sel, jump_taken).
//  Top holds pc, ir, flags, state registers only.
// TESTING
//  Reset then ROM {0x13,0x22,0x50,0xF0}, run=1 -> en_bus_out at cycle 6 with operand/alu_sel 0; halted=1 after cycle 8.
//  LIT 0xF, ADDI 0x1 with c_z=2'b11 driven on ADDI EXEC -> flags=2'b11; following JC target 0x40 -> pc=0x40.
//  CMPI with c_z=2'b00 then JZ 0x20 at addr 0x04 -> not taken, next fetch addr 0x06; JNZ same -> pc=0x20.
//  JMP at addr 0xFF, ROM[0x00]=0x10 -> EXEC prog_addr=0x00, pc=0x10; NOP at 0xFF -> pc wraps to 0x00.
//  run=0 for 5 cycles in FETCH -> pc and outputs frozen; run pulse 1 cycle -> exactly one instruction executes.
//  Assert reset during ADDI EXEC -> en_accu falls without clock edge, flags stay 0, pc=RESET_PC, state FETCH.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, ALU selects,
// FSM states and flag bit positions.
package instr_sequencer_pkg;

  // Opcodes live in ir[7:4]
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LIT   = 4'h1;
  localparam logic [3:0] OP_ADDI  = 4'h2;
  localparam logic [3:0] OP_CMPI  = 4'h3;
  localparam logic [3:0] OP_NANDI = 4'h4;
  localparam logic [3:0] OP_OUT   = 4'h5;
  localparam logic [3:0] OP_JMP   = 4'h6;
  localparam logic [3:0] OP_JC    = 4'h7;
  localparam logic [3:0] OP_JNC   = 4'h8;
  localparam logic [3:0] OP_JZ    = 4'h9;
  localparam logic [3:0] OP_JNZ   = 4'hA;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // ALU select codes understood by the datapath
  localparam logic [2:0] ALU_ST    = 3'd0;
  localparam logic [2:0] ALU_COMPI = 3'd1;
  localparam logic [2:0] ALU_LIT   = 3'd2;
  localparam logic [2:0] ALU_ADDI  = 3'd3;
  localparam logic [2:0] ALU_NANDI = 3'd4;

  // Flag bit positions, shared by c_z and the latched flags
  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StExec  = 2'd1,
    StHalt  = 2'd2
  } state_e;

endpackage

// File: rtl/instr_sequencer_if.sv
// Sequencer <-> ROM/datapath signal bundle. master = sequencer side.
interface instr_sequencer_if #(
  parameter int unsigned PC_W = 8
);
  logic            run;
  logic [PC_W-1:0] prog_addr;
  logic [7:0]      prog_data;
  logic [1:0]      c_z;
  logic            en_accu;
  logic            en_bus_in;
  logic            en_bus_out;
  logic [2:0]      alu_sel;
  logic [3:0]      operand;
  logic [1:0]      flags;
  logic            halted;

  modport master (
    input  run, prog_data, c_z,
    output prog_addr, en_accu, en_bus_in, en_bus_out, alu_sel, operand, flags, halted
  );

  modport slave (
    output run, prog_data, c_z,
    input  prog_addr, en_accu, en_bus_in, en_bus_out, alu_sel, operand, flags, halted
  );
endinterface

// File: rtl/seq_decode.sv
// Combinational instruction decoder: opcode + state + latched flags ->
// datapath controls and sequencing hints. All controls are 0 outside EXEC.
module seq_decode
  import instr_sequencer_pkg::*;
(
  input  state_e     state,
  input  logic [3:0] opcode,
  input  logic [1:0] flags,
  output logic       en_accu,
  output logic       en_bus_in,
  output logic       en_bus_out,
  output logic [2:0] alu_sel,
  output logic       upd_flags,
  output logic       is_jump,
  output logic       jump_taken,
  output logic       is_halt
);

  // Decode controls from the held opcode; only EXEC produces non-zero outputs
  always_comb begin
    en_accu    = 1'b0;
    en_bus_in  = 1'b0;
    en_bus_out = 1'b0;
    alu_sel    = ALU_ST;
    upd_flags  = 1'b0;
    is_jump    = 1'b0;
    jump_taken = 1'b0;
    is_halt    = 1'b0;
    if (state == StExec) begin
      case (opcode)
        OP_LIT: begin
          alu_sel = ALU_LIT; en_bus_in = 1'b1; en_accu = 1'b1; upd_flags = 1'b1;
        end
        OP_ADDI: begin
          alu_sel = ALU_ADDI; en_bus_in = 1'b1; en_accu = 1'b1; upd_flags = 1'b1;
        end
        OP_CMPI: begin
          alu_sel = ALU_COMPI; en_bus_in = 1'b1; upd_flags = 1'b1;
        end
        OP_NANDI: begin
          alu_sel = ALU_NANDI; en_bus_in = 1'b1; en_accu = 1'b1; upd_flags = 1'b1;
        end
        OP_OUT: begin
          alu_sel = ALU_ST; en_bus_out = 1'b1;
        end
        OP_JMP: begin
          is_jump = 1'b1; jump_taken = 1'b1;
        end
        OP_JC: begin
          is_jump = 1'b1; jump_taken = flags[FLAG_C];
        end
        OP_JNC: begin
          is_jump = 1'b1; jump_taken = ~flags[FLAG_C];
        end
        OP_JZ: begin
          is_jump = 1'b1; jump_taken = flags[FLAG_Z];
        end
        OP_JNZ: begin
          is_jump = 1'b1; jump_taken = ~flags[FLAG_Z];
        end
        OP_HALT: is_halt = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Two-phase (FETCH/EXEC) instruction sequencer driving a 4-bit accumulator
// datapath. Holds pc, ir, flags and state; controls come from seq_decode.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned RESET_PC = 0
) (
  input logic                clk,
  input logic                reset,
  instr_sequencer_if.master  bus
);

  localparam logic [PC_W-1:0] ResetPc = PC_W'(RESET_PC);

  logic [PC_W-1:0] pc_q;
  logic [7:0]      ir_q;
  logic [1:0]      flags_q;
  state_e          state_q;

  logic upd_flags, is_jump, jump_taken, is_halt;

  seq_decode u_decode (
    .state      (state_q),
    .opcode     (ir_q[7:4]),
    .flags      (flags_q),
    .en_accu    (bus.en_accu),
    .en_bus_in  (bus.en_bus_in),
    .en_bus_out (bus.en_bus_out),
    .alu_sel    (bus.alu_sel),
    .upd_flags  (upd_flags),
    .is_jump    (is_jump),
    .jump_taken (jump_taken),
    .is_halt    (is_halt)
  );

  // Output wiring; operand is only presented while executing
  always_comb begin
    bus.prog_addr = pc_q;
    bus.operand   = (state_q == StExec) ? ir_q[3:0] : 4'h0;
    bus.flags     = flags_q;
    bus.halted    = (state_q == StHalt);
  end

  // Sequencer FSM; in EXEC of a jump, pc already addresses the target byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= ResetPc;
      ir_q    <= 8'h00;
      flags_q <= 2'b00;
      state_q <= StFetch;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (bus.run) begin
            ir_q    <= bus.prog_data;
            pc_q    <= pc_q + PC_W'(1);
            state_q <= StExec;
          end
        end
        StExec: begin
          if (upd_flags) flags_q <= bus.c_z;
          if (is_halt) begin
            state_q <= StHalt;
          end else begin
            state_q <= StFetch;
            if (is_jump) begin
              pc_q <= jump_taken ? bus.prog_data[PC_W-1:0] : pc_q + PC_W'(1);
            end
          end
        end
        StHalt: ;
        default: state_q <= StFetch;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench: instruction-level reference model, directed scenarios
// and a randomized program run.
module tb_instr_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  instr_sequencer_if #(.PC_W(8)) bus ();

  instr_sequencer #(
    .PC_W     (8),
    .RESET_PC (0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] rom [256];
  assign bus.prog_data = rom[bus.prog_addr];

  int checks = 0;
  int errors = 0;

  // Reference model state (architectural view)
  logic [7:0] m_pc;
  logic [1:0] m_flags;
  bit         m_halted;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {en_accu, en_bus_in, en_bus_out, alu_sel[2:0], operand[3:0], halted}
  function automatic logic [10:0] ctl_now();
    return {bus.en_accu, bus.en_bus_in, bus.en_bus_out, bus.alu_sel, bus.operand, bus.halted};
  endfunction

  // Expected {en_accu, en_bus_in, en_bus_out, alu_sel} for an executing opcode
  function automatic logic [5:0] exp_ctl(input logic [3:0] op);
    case (op)
      4'h1: return {3'b110, 3'd2};
      4'h2: return {3'b110, 3'd3};
      4'h3: return {3'b010, 3'd1};
      4'h4: return {3'b110, 3'd4};
      4'h5: return {3'b001, 3'd0};
      default: return 6'd0;
    endcase
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  task automatic do_reset();
    bus.run = 1'b0;
    bus.c_z = 2'b00;
    reset = 1'b1;
    #1;
    check("rst_ctl", ctl_now(), 11'd0);
    check("rst_pc", bus.prog_addr, 8'h00);
    check("rst_flags", bus.flags, 2'b00);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_pc = 8'h00;
    m_flags = 2'b00;
    m_halted = 0;
  endtask

  // Execute one instruction; entered and left at a negedge in FETCH
  task automatic do_instr(input int holds, input int cz_force, input bit run_exec);
    logic [7:0] ins, nxt, tgt;
    logic [3:0] op;
    logic [1:0] cz;
    bit taken;
    for (int i = 0; i < holds; i++) begin
      bus.run = 1'b0;
      check("hold_pc", bus.prog_addr, m_pc);
      check("hold_ctl", ctl_now(), 11'd0);
      @(negedge clk);
    end
    bus.run = 1'b1;
    check("fetch_pc", bus.prog_addr, m_pc);
    check("fetch_ctl", ctl_now(), 11'd0);
    check("fetch_flags", bus.flags, m_flags);
    ins = rom[m_pc];
    op = ins[7:4];
    @(negedge clk);
    cz = (cz_force < 0) ? 2'($urandom) : 2'(cz_force);
    bus.c_z = cz;
    bus.run = run_exec;
    nxt = m_pc + 8'd1;
    check("exec_addr", bus.prog_addr, nxt);
    check("exec_ctl", ctl_now(), {exp_ctl(op), ins[3:0], 1'b0});
    m_pc = nxt;
    case (op)
      4'h1, 4'h2, 4'h3, 4'h4: m_flags = cz;
      4'h6, 4'h7, 4'h8, 4'h9, 4'hA: begin
        tgt = rom[nxt];
        case (op)
          4'h6: taken = 1;
          4'h7: taken = m_flags[0];
          4'h8: taken = !m_flags[0];
          4'h9: taken = m_flags[1];
          default: taken = !m_flags[1];
        endcase
        m_pc = taken ? tgt : nxt + 8'd1;
      end
      4'hF: m_halted = 1;
      default: ;
    endcase
    @(negedge clk);
    if (m_halted) begin
      for (int i = 0; i < 3; i++) begin
        bus.run = 1'b1;
        check("halt_ctl", ctl_now(), 11'd1);
        check("halt_pc", bus.prog_addr, m_pc);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.run = 1'b0;
    bus.c_z = 2'b00;
    clear_rom();
    @(negedge clk);

    // Basic program: LIT 3, ADDI 2, OUT, HALT
    do_reset();
    rom[0] = 8'h13; rom[1] = 8'h22; rom[2] = 8'h50; rom[3] = 8'hF0;
    for (int i = 0; i < 4; i++) do_instr(0, -1, 1'b1);

    // ADDI with carry+zero, then taken JC
    clear_rom();
    do_reset();
    rom[0] = 8'h1F; rom[1] = 8'h21; rom[2] = 8'h70; rom[3] = 8'h40;
    do_instr(0, 0, 1'b1);
    do_instr(0, 3, 1'b1);
    check("flags_after_addi", bus.flags, 2'b11);
    do_instr(0, -1, 1'b1);
    check("jc_target", bus.prog_addr, 8'h40);

    // CMPI clears flags; JZ at 0x04 not taken, JNZ taken
    for (int v = 0; v < 2; v++) begin
      clear_rom();
      do_reset();
      rom[3] = 8'h30; rom[4] = (v == 0) ? 8'h90 : 8'hA0; rom[5] = 8'h20;
      for (int i = 0; i < 5; i++) do_instr(0, 0, 1'b1);
      check("jz_jnz_next", bus.prog_addr, (v == 0) ? 8'h06 : 8'h20);
    end

    // JMP at 0xFF takes its target from 0x00
    clear_rom();
    do_reset();
    rom[0] = 8'h10; rom[1] = 8'h60; rom[2] = 8'hFF; rom[255] = 8'h60;
    for (int i = 0; i < 3; i++) do_instr(0, -1, 1'b1);
    check("jmp_wrap", bus.prog_addr, 8'h10);

    // NOP at 0xFF wraps pc to 0x00, with a 5-cycle hold and single-step pulses
    clear_rom();
    do_reset();
    rom[0] = 8'h60; rom[1] = 8'hFF; rom[255] = 8'h00;
    do_instr(5, -1, 1'b0);
    do_instr(2, -1, 1'b0);
    check("nop_wrap", bus.prog_addr, 8'h00);
    do_instr(3, -1, 1'b0);

    // Reset asserted during ADDI EXEC drops enables without a clock edge
    clear_rom();
    do_reset();
    rom[0] = 8'h22;
    bus.run = 1'b1;
    @(negedge clk);
    bus.c_z = 2'b11;
    check("pre_rst_accu", bus.en_accu, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("async_rst_accu", bus.en_accu, 1'b0);
    check("async_rst_pc", bus.prog_addr, 8'h00);
    @(negedge clk);
    check("async_rst_flags", bus.flags, 2'b00);
    reset = 1'b0;
    m_pc = 8'h00; m_flags = 2'b00; m_halted = 0;
    do_instr(0, 2, 1'b1);

    // Randomized program with random holds, flags and run in EXEC
    do_reset();
    for (int i = 0; i < 256; i++) rom[i] = {4'($urandom_range(0, 14)), 4'($urandom)};
    for (int n = 0; n < 250; n++) begin
      do_instr(($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0, -1, 1'($urandom));
    end
    rom[m_pc] = 8'hF0;
    do_instr(0, -1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
